ctrl_desp32: RTL and testbench

- Transmit sequencer directly upstream of the 32-bit shift register.
- Accepts a parallel word over a valid/ready handshake and parallel-loads it into the register.
- Then drives WIDTH shift cycles so the word leaves bit-serially on the register's sOut.
- Marks each serial bit with a strobe so the downstream serial consumer knows when sOut is meaningful.

---
 rtl/ctrl_desp32_if.sv | 36 +++
 rtl/ctrl_desp32.sv | 164 ++++++++++++++++
 tb/tb_ctrl_desp32.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_desp32_if.sv
// Upstream word handshake for the serial transmit sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready from the slave side gates acceptance of in_valid/in_data.
// Signals: in_valid/in_ready handshake, in_data word, in_dir shift direction,
//          keep (rotate instead of shift) only when CTRL_DESP_ROT_EN is defined.
interface ctrl_desp32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
`ifdef CTRL_DESP_ROT_EN
  logic             keep;
`endif

  modport master (
    output in_valid,
    output in_data,
    output in_dir,
`ifdef CTRL_DESP_ROT_EN
    output keep,
`endif
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dir,
`ifdef CTRL_DESP_ROT_EN
    input  keep,
`endif
    output in_ready
  );
endinterface

// File: rtl/ctrl_desp32.sv
// Transmit sequencer: parallel-loads a word into a WIDTH-bit shift register, then shifts it out bit-serially.
// Latency: first serial bit valid 2 cycles after accept; accept-to-accept spacing WIDTH+3 cycles.
// Backpressure: in_ready only in IDLE with abort low; abort cancels a word in LOAD/SHIFT without a done pulse.
// Ports: clk, rst_n (async active-low); up (slave handshake: in_valid/in_ready/in_data/in_dir[/keep]);
//        abort; register controls enb/dir/sIn/modo/D; bit_vld/bit_last strobes; busy; done pulse.
// Optional: CTRL_DESP_ROT_EN adds keep, selecting rotate mode so the register retains the word.
module ctrl_desp32 #(
  parameter int   WIDTH = 32,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  ctrl_desp32_if.slave     up,
  input  logic             abort,
  output logic             enb,
  output logic             dir,
  output logic             sIn,
  output logic [1:0]       modo,
  output logic [WIDTH-1:0] D,
  output logic             bit_vld,
  output logic             bit_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             dir_q, dir_d;
  logic             keep_q, keep_d;
  logic             enb_q, enb_d;
  logic [1:0]       modo_q, modo_d;
  logic             sin_q, sin_d;
  logic             bit_vld_q, bit_vld_d;
  logic             bit_last_q, bit_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             keep_in;

`ifdef CTRL_DESP_ROT_EN
  assign keep_in = up.keep;
`else
  assign keep_in = 1'b0;
`endif

  // Combinational ready so abort can veto an accept on the same edge.
  assign up.in_ready = (state_q == ST_IDLE) && !abort;
  assign accept      = up.in_valid && up.in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    d_d     = d_q;
    dir_d   = dir_q;
    keep_d  = keep_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          d_d     = up.in_data;
          dir_d   = up.in_dir;
          keep_d  = keep_in;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          state_d = ST_SHIFT;
          count_d = CW'(WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = ST_DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    enb_d      = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    busy_d     = enb_d;
    bit_vld_d  = (state_d == ST_SHIFT);
    bit_last_d = bit_vld_d && (count_d == '0);
    done_d     = (state_d == ST_DONE);
    sin_d      = FILL;
    if (state_d == ST_LOAD) begin
      modo_d = MODO_LOAD;
    end else if (state_d == ST_SHIFT) begin
      modo_d = keep_d ? MODO_ROT : MODO_SHIFT;
    end else begin
      modo_d = MODO_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      d_q        <= '0;
      dir_q      <= 1'b0;
      keep_q     <= 1'b0;
      enb_q      <= 1'b0;
      modo_q     <= MODO_SHIFT;
      sin_q      <= FILL;
      bit_vld_q  <= 1'b0;
      bit_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      d_q        <= d_d;
      dir_q      <= dir_d;
      keep_q     <= keep_d;
      enb_q      <= enb_d;
      modo_q     <= modo_d;
      sin_q      <= sin_d;
      bit_vld_q  <= bit_vld_d;
      bit_last_q <= bit_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign enb      = enb_q;
  assign dir      = dir_q;
  assign sIn      = sin_q;
  assign modo     = modo_q;
  assign D        = d_q;
  assign bit_vld  = bit_vld_q;
  assign bit_last = bit_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ctrl_desp32.sv
// Bench for ctrl_desp32: drives words over the handshake, models the downstream 32-bit register,
// and checks the serial bit stream, strobes and handshake timing against expectations derived from
// the word itself (bit k of the stream = in_data[31-k] left, in_data[k] right).
module tb_ctrl_desp32;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         enb, dir, sin, bit_vld, bit_last, busy, done;
  logic [1:0]   modo;
  logic [W-1:0] d_out;
  logic [W-1:0] reg_q = '0;
  logic         sout;
  int           n_cmp = 0;
  int           n_err = 0;

  ctrl_desp32_if #(.WIDTH(W)) up_if ();

  ctrl_desp32 #(.WIDTH(W), .FILL(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up       (up_if),
    .abort    (abort),
    .enb      (enb),
    .dir      (dir),
    .sIn      (sin),
    .modo     (modo),
    .D        (d_out),
    .bit_vld  (bit_vld),
    .bit_last (bit_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Downstream shift register driven by the sequencer.
  always @(posedge clk) begin
    if (enb) begin
      case (modo)
        2'b10:   reg_q <= d_out;
        2'b00:   reg_q <= dir ? {sin, reg_q[W-1:1]} : {reg_q[W-2:0], sin};
        2'b01:   reg_q <= dir ? {reg_q[0], reg_q[W-1:1]} : {reg_q[W-2:0], reg_q[W-1]};
        default: reg_q <= 'x;
      endcase
    end
  end
  assign sout = dir ? reg_q[0] : reg_q[W-1];

  // {enb, modo, busy, bit_vld, bit_last, done, in_ready}
  function automatic logic [7:0] obs();
    return {enb, modo, busy, bit_vld, bit_last, done, up_if.in_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_keep(input logic k);
`ifdef CTRL_DESP_ROT_EN
    up_if.keep = k;
`else
    if (k) $display("note: keep requested without rotate support");
`endif
  endtask

  // Sends one word and checks every cycle until the sequencer is idle again.
  // abort_at / reset_at: SHIFT cycle index (0-based) at which to abort / reset, -1 for none.
  task automatic send_and_check(input logic [W-1:0] w, input logic d, input logic k,
                                input int abort_at, input int reset_at, input string name);
    logic [7:0] ev;
    logic       eb;
    int         n;
    n = 0;
    while (!up_if.in_ready && n < 60) begin
      step();
      n++;
    end
    if (!up_if.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL %s ready_timeout: in_ready=%b required 1", name, up_if.in_ready);
      return;
    end
    up_if.in_valid = 1'b1;
    up_if.in_data  = w;
    up_if.in_dir   = d;
    drive_keep(k);
    step();
    up_if.in_valid = 1'b0;
    up_if.in_data  = $urandom;
    up_if.in_dir   = 1'($urandom_range(0, 1));
    drive_keep(1'b0);
    #1;
    ev = {1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== ev) begin
      n_err++;
      $display("FAIL %s load_ctrl: got %b required %b", name, obs(), ev);
    end
    n_cmp++;
    if ({dir, d_out} !== {d, w}) begin
      n_err++;
      $display("FAIL %s load_data: got dir=%b D=%h required dir=%b D=%h", name, dir, d_out, d, w);
    end
    step();
    for (int i = 0; i < W; i++) begin
      ev = {1'b1, (k ? 2'b01 : 2'b00), 1'b1, 1'b1, (i == W - 1), 1'b0, 1'b0};
      n_cmp++;
      if (obs() !== ev) begin
        n_err++;
        $display("FAIL %s shift_ctrl[%0d]: got %b required %b", name, i, obs(), ev);
      end
      eb = d ? w[i] : w[W-1-i];
      n_cmp++;
      if (sout !== eb) begin
        n_err++;
        $display("FAIL %s serial_bit[%0d]: got %b required %b", name, i, sout, eb);
      end
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({obs() & 8'hFE, sin, dir, d_out} !== {8'h00, 1'b0, 1'b0, {W{1'b0}}}) begin
          n_err++;
          $display("FAIL %s reset_mid: got obs=%b sIn=%b dir=%b D=%h required all zero",
                   name, obs(), sin, dir, d_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (obs() !== 8'b0000_0001) begin
          n_err++;
          $display("FAIL %s after_reset: got %b required 00000001", name, obs());
        end
        return;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 8'b0000_0001) begin
          n_err++;
          $display("FAIL %s after_abort: got %b required 00000001", name, obs());
        end
        step();
        n_cmp++;
        if (obs() !== 8'b0000_0001) begin
          n_err++;
          $display("FAIL %s no_done_after_abort: got %b required 00000001", name, obs());
        end
        return;
      end
      step();
    end
    n_cmp++;
    if (obs() !== 8'b0000_0010) begin
      n_err++;
      $display("FAIL %s done_ctrl: got %b required 00000010", name, obs());
    end
    n_cmp++;
    if (reg_q !== (k ? w : {W{1'b0}})) begin
      n_err++;
      $display("FAIL %s reg_final: got %h required %h", name, reg_q, (k ? w : {W{1'b0}}));
    end
    step();
    n_cmp++;
    if (obs() !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL %s idle_after_done: got %b required 00000001", name, obs());
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({obs() & 8'hFE, sin, dir, d_out} !== {8'h00, 1'b0, 1'b0, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_values: got obs=%b sIn=%b dir=%b D=%h required all zero",
               obs(), sin, dir, d_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs() !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL reset_release: got %b required 00000001", obs());
    end
  endtask

  task automatic test_shift_left();
    send_and_check(32'hA5000001, 1'b0, 1'b0, -1, -1, "shift_left");
  endtask

  task automatic test_shift_right();
    send_and_check(32'hA5000001, 1'b1, 1'b0, -1, -1, "shift_right");
  endtask

  task automatic test_reset_mid_shift();
    // SHIFT index 14 is the cycle with count == 17.
    send_and_check($urandom, 1'b0, 1'b0, -1, 14, "reset_mid");
    send_and_check(32'h0F0F1234, 1'b1, 1'b0, -1, -1, "post_reset");
  endtask

  task automatic test_abort();
    send_and_check($urandom, 1'b0, 1'b0, 9, -1, "abort_shift");
    abort = 1'b1;
    up_if.in_valid = 1'b1;
    up_if.in_data  = $urandom;
    #1;
    n_cmp++;
    if (up_if.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle_ready: got %b required 0", up_if.in_ready);
    end
    step();
    n_cmp++;
    if (obs() !== 8'b0000_0000) begin
      n_err++;
      $display("FAIL abort_idle_block: got %b required 00000000", obs());
    end
    abort = 1'b0;
    up_if.in_valid = 1'b0;
    #1;
    send_and_check(32'h80000001, 1'b0, 1'b0, -1, -1, "after_abort_word");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w[2];
    logic         dd[2];
    int           acc_at[$];
    logic         exp_bits[$];
    logic         got_bits[$];
    int           cyc;
    int           low;
    cyc = 0;
    low = 0;
    for (int j = 0; j < 2; j++) begin
      w[j]  = $urandom;
      dd[j] = 1'($urandom_range(0, 1));
      for (int i = 0; i < W; i++) exp_bits.push_back(dd[j] ? w[j][i] : w[j][W-1-i]);
    end
    up_if.in_valid = 1'b1;
    up_if.in_data  = w[0];
    up_if.in_dir   = dd[0];
    #1;
    while (cyc < 200 && !(acc_at.size() == 2 && got_bits.size() >= 2 * W)) begin
      if (up_if.in_valid && up_if.in_ready) acc_at.push_back(cyc);
      else if (acc_at.size() == 1 && !up_if.in_ready) low++;
      if (bit_vld) got_bits.push_back(sout);
      step();
      cyc++;
      if (acc_at.size() == 1) begin
        up_if.in_data = w[1];
        up_if.in_dir  = dd[1];
      end
      if (acc_at.size() == 2) up_if.in_valid = 1'b0;
    end
    n_cmp++;
    if (acc_at.size() != 2) begin
      n_err++;
      $display("FAIL b2b_accepts: got %0d required 2", acc_at.size());
    end else begin
      n_cmp++;
      if (acc_at[1] - acc_at[0] != W + 3) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d required %0d", acc_at[1] - acc_at[0], W + 3);
      end
      n_cmp++;
      if (low != W + 2) begin
        n_err++;
        $display("FAIL b2b_ready_low: got %0d required %0d", low, W + 2);
      end
    end
    n_cmp++;
    if (got_bits.size() != 2 * W) begin
      n_err++;
      $display("FAIL b2b_bit_count: got %0d required %0d", got_bits.size(), 2 * W);
    end else begin
      for (int i = 0; i < 2 * W; i++) begin
        n_cmp++;
        if (got_bits[i] !== exp_bits[i]) begin
          n_err++;
          $display("FAIL b2b_bit[%0d]: got %b required %b", i, got_bits[i], exp_bits[i]);
        end
      end
    end
    up_if.in_valid = 1'b0;
    cyc = 0;
    while (!up_if.in_ready && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    logic         d, k;
    int           ab, gap;
    for (int t = 0; t < 8; t++) begin
      w  = $urandom;
      d  = 1'($urandom_range(0, 1));
`ifdef CTRL_DESP_ROT_EN
      k  = 1'($urandom_range(0, 1));
`else
      k  = 1'b0;
`endif
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      send_and_check(w, d, k, ab, -1, "random");
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        up_if.in_data = $urandom;
        step();
        n_cmp++;
        if (obs() !== 8'b0000_0001) begin
          n_err++;
          $display("FAIL random_gap: got %b required 00000001", obs());
        end
      end
    end
  endtask

`ifdef CTRL_DESP_ROT_EN
  task automatic test_rotate();
    send_and_check(32'hDEADBEEF, 1'b0, 1'b1, -1, -1, "rotate_left");
    send_and_check(32'hDEADBEEF, 1'b1, 1'b1, -1, -1, "rotate_right");
  endtask
`endif

  initial begin
    up_if.in_valid = 1'b0;
    up_if.in_data  = '0;
    up_if.in_dir   = 1'b0;
    drive_keep(1'b0);
    test_reset();
    test_shift_left();
    test_shift_right();
    test_reset_mid_shift();
    test_abort();
    test_back_to_back();
`ifdef CTRL_DESP_ROT_EN
    test_rotate();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
